// File: rtl/bp_fe_bht_ctrl_if.sv
// Update channel from the backend branch-resolution logic into the BHT controller.
// The master side drives a resolved branch; the slave side accepts it through upd_ready.
interface bp_fe_bht_ctrl_if #(
    parameter int unsigned bht_idx_width_p = 8
);

    logic                       upd_v;
    logic [bht_idx_width_p-1:0] upd_idx;
    logic                       upd_correct;
    logic                       upd_ready;

    modport master (
        output upd_v,
        output upd_idx,
        output upd_correct,
        input  upd_ready
    );

    modport slave (
        input  upd_v,
        input  upd_idx,
        input  upd_correct,
        output upd_ready
    );

endinterface

// File: rtl/bp_fe_bht_ctrl.sv
// Front-end BHT controller: init sweep, buffered counter updates and read gating/hazards.
// Owns the BHT write port (init or update, never both) and qualifies the predict read.
module bp_fe_bht_ctrl #(
    parameter int unsigned bht_idx_width_p = 8,
    parameter int unsigned upd_fifo_els_p  = 2
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       init_i,

    bp_fe_bht_ctrl_if.slave            upd,

    input  logic                       r_v_i,
    input  logic [bht_idx_width_p-1:0] r_idx_i,

    output logic                       bht_w_v_o,
    output logic [bht_idx_width_p-1:0] bht_idx_w_o,
    output logic                       bht_correct_o,
    output logic                       bht_init_v_o,
    output logic                       bht_r_v_o,
    output logic [bht_idx_width_p-1:0] bht_r_idx_o,
    output logic                       hazard_o,
    output logic                       busy_o
);

    localparam int unsigned PtrW = $clog2(upd_fifo_els_p);

    localparam logic [PtrW:0]                FifoEls = (PtrW + 1)'(upd_fifo_els_p);
    localparam logic [bht_idx_width_p-1:0]   LastIdx = '1;

    typedef enum logic [1:0] {
        StReset,
        StInit,
        StReady
    } state_e;

    state_e                     state_q, state_d;
    logic [bht_idx_width_p-1:0] cnt_q, cnt_d;

    logic [bht_idx_width_p-1:0] idx_mem [upd_fifo_els_p];
    logic                       corr_mem [upd_fifo_els_p];
    logic [PtrW-1:0]            wptr_q, wptr_d;
    logic [PtrW-1:0]            rptr_q, rptr_d;
    logic [PtrW:0]              count_q, count_d;

    logic                       in_ready;
    logic                       in_init;
    logic                       fifo_empty;
    logic                       fifo_full;
    logic                       flush;
    logic                       enq;
    logic                       deq;
    logic                       upd_ready;
    logic [bht_idx_width_p-1:0] head_idx;
    logic                       head_correct;
    logic                       match;

    // ---------------------------------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------------------------------

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (reset_i) begin
            state_d = StReset;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StReset: begin
                    state_d = StInit;
                    cnt_d   = '0;
                end
                StInit: begin
                    // A re-init request mid-sweep restarts from entry 0.
                    if (init_i) begin
                        cnt_d = '0;
                    end else if (cnt_q == LastIdx) begin
                        state_d = StReady;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StReady: begin
                    if (init_i) begin
                        state_d = StInit;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = StReset;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
    end

    // ---------------------------------------------------------------------------------------
    // Update FIFO
    // ---------------------------------------------------------------------------------------

    assign in_ready   = ~reset_i & (state_q == StReady);
    assign in_init    = ~reset_i & (state_q == StInit);
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FifoEls);

    // Acceptance ignores a same-cycle dequeue so upd_ready never depends on the write port.
    assign upd_ready     = in_ready & ~fifo_full & ~init_i;
    assign upd.upd_ready = upd_ready;
    assign enq           = upd.upd_v & upd_ready;
    assign deq           = in_ready & ~init_i & ~fifo_empty;

    // Leaving READY for INIT drops everything still buffered.
    assign flush = reset_i | (in_ready & init_i);

    assign head_idx     = idx_mem[rptr_q];
    assign head_correct = corr_mem[rptr_q];

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (enq) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (deq) begin
                rptr_d = rptr_q + 1'b1;
            end
            case ({enq, deq})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        wptr_q  <= wptr_d;
        rptr_q  <= rptr_d;
        count_q <= count_d;
    end

    always_ff @(posedge clk_i) begin
        if (enq) begin
            idx_mem[wptr_q]  <= upd.upd_idx;
            corr_mem[wptr_q] <= upd.upd_correct;
        end
    end

    // ---------------------------------------------------------------------------------------
    // Read-after-pending-write hazard
    // ---------------------------------------------------------------------------------------

    always_comb begin
        logic [PtrW-1:0] offset;
        match  = 1'b0;
        offset = '0;
        for (int unsigned i = 0; i < upd_fifo_els_p; i++) begin
            // Slot i is live when its distance from the head is below the occupancy.
            offset = PtrW'(i) - rptr_q;
            if (({1'b0, offset} < count_q) && (idx_mem[i] == r_idx_i)) begin
                match = 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------------------------

    always_comb begin
        bht_w_v_o     = 1'b0;
        bht_idx_w_o   = '0;
        bht_correct_o = 1'b0;
        bht_init_v_o  = 1'b0;
        if (in_init) begin
            bht_init_v_o = 1'b1;
            bht_idx_w_o  = cnt_q;
        end else if (deq) begin
            bht_w_v_o     = 1'b1;
            bht_idx_w_o   = head_idx;
            bht_correct_o = head_correct;
        end
    end

    assign bht_r_v_o   = r_v_i & in_ready;
    assign bht_r_idx_o = r_idx_i;
    assign hazard_o    = r_v_i & in_ready & match;
    assign busy_o      = ~in_ready;

endmodule
